// File: rtl/muldiv_unit.sv
// Iterative 32x32 mult/multu/div/divu into HI/LO: 32 RUN cycles plus one FIX cycle, done pulses after FIX.
// No backpressure: busy stalls the datapath; start and mthi/mtlo are dropped while busy.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hiwe,
  input  logic             lowe,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     srca_q, srca_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic                 neg_q, neg_d;
  logic                 rneg_q, rneg_d;
  logic                 done_q, done_d;

  logic                 sign_a, sign_b;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       rem_sh, diff;
  logic                 q_bit;
  logic [WIDTH-1:0]     rem_next;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quot, rem;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q != IDLE);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end

  always_comb begin
    sign_a = ~op[0] & srca[WIDTH-1];
    sign_b = ~op[0] & srcb[WIDTH-1];
    abs_a  = sign_a ? (~srca + 1'b1) : srca;
    abs_b  = sign_b ? (~srcb + 1'b1) : srcb;

    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);

    // Partial remainder never exceeds the divisor, so only the shifted-in bit can overflow WIDTH.
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    diff     = rem_sh - {1'b0, b_q};
    q_bit    = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];

    prod = neg_q  ? (~acc_q + 1'b1) : acc_q;
    quot = neg_q  ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem  = rneg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    cnt_d  = cnt_q;
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    srca_d = srca_q;
    acc_d  = acc_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (hiwe) hi_d = wd;
        if (lowe) lo_d = wd;
        if (start) begin
          op_d   = op;
          a_d    = abs_a;
          b_d    = abs_b;
          srca_d = srca;
          neg_d  = sign_a ^ sign_b;
          rneg_d = sign_a;
          acc_d  = '0;
          cnt_d  = '0;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q[1]) begin
          acc_d = {rem_next, acc_q[WIDTH-2:0], q_bit};
          a_d   = a_q << 1;
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          b_d   = b_q >> 1;
        end
      end
      FIX: begin
        done_d = 1'b1;
        if (op_q[1]) begin
          if (b_q == '0) begin
            lo_d = '1;
            hi_d = srca_q;
          end else begin
            lo_d = quot;
            hi_d = rem;
          end
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      srca_q <= '0;
      acc_q  <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      srca_q <= srca_d;
      acc_q  <= acc_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: fixed vectors, random ops against an arithmetic model, and corner sequences.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start, hiwe, lowe;
  logic [1:0]  op;
  logic [31:0] srca, srcb, wd;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_chk  = 0;
  int n_fail = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .hiwe(hiwe), .lowe(lowe), .wd(wd), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    int          sq, sr;
    case (o)
      2'b00: begin
        sp = longint'(int'(a)) * longint'(int'(b));
        return sp;
      end
      2'b01: begin
        up = {32'b0, a} * {32'b0, b};
        return up;
      end
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sq = int'(a) / int'(b);
        sr = int'(a) % int'(b);
        return {sr, sq};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; srca = a; srcb = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; hiwe = 1'b0; lowe = 1'b0;
    op = 2'($urandom); srca = $urandom; srcb = $urandom;
  endtask

  task automatic wait_done(output int busy_cycles, output bit got);
    busy_cycles = 0;
    got = 1'b0;
    for (int i = 0; i < 45 && !got; i++) begin
      if (done) got = 1'b1;
      else begin
        if (busy) busy_cycles++;
        @(negedge clk);
      end
    end
  endtask

  task automatic run_check(input string nm, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp);
    int bc;
    bit got;
    issue(o, a, b);
    wait_done(bc, got);
    chk({nm, ".done_seen"}, 64'(got), 64'd1);
    chk({nm, ".busy_cycles"}, 64'(bc), 64'd33);
    chk({nm, ".busy_in_done"}, 64'(busy), 64'd0);
    chk({nm, ".hi"}, 64'(hi), 64'(exp[63:32]));
    chk({nm, ".lo"}, 64'(lo), 64'(exp[31:0]));
  endtask

  initial begin
    int  bc, bc2;
    bit  got, seen;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4]  = '{2'b11, 32'd7,         32'd2,         32'd1,         32'd3};
    vecs[5]  = '{2'b11, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF};
    vecs[6]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[7]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[8]  = '{2'b00, 32'd6,         32'd7,         32'd0,         32'd42};
    vecs[9]  = '{2'b01, 32'h8000_0000, 32'd2,         32'd1,         32'd0};
    vecs[10] = '{2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};

    reset = 1'b1; start = 1'b0; hiwe = 1'b0; lowe = 1'b0;
    op = 2'b00; srca = '0; srcb = '0; wd = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.hi", 64'(hi), 64'd0);
    chk("reset.lo", 64'(lo), 64'd0);

    hiwe = 1'b1; wd = 32'hAAAA_AAAA;
    @(negedge clk);
    hiwe = 1'b0; lowe = 1'b1; wd = 32'h5555_0001;
    @(negedge clk);
    lowe = 1'b0;
    chk("mthi.hi", 64'(hi), 64'hAAAA_AAAA);
    chk("mtlo.lo", 64'(lo), 64'h5555_0001);

    for (int i = 0; i < 11; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo});
      @(negedge clk);
      chk($sformatf("vec%0d.done_one_cycle", i), 64'(done), 64'd0);
    end

    // mthi on the accepting edge lands, then mid-run start/mthi are dropped.
    hiwe = 1'b1; wd = 32'h0000_5555;
    issue(2'b11, 32'd7, 32'd2);
    chk("midrun.accept_mthi", 64'(hi), 64'h0000_5555);
    bc = 0;
    for (int i = 0; i < 5; i++) begin
      if (busy) bc++;
      if (i == 2) begin
        start = 1'b1; op = 2'b00; srca = 32'd5; srcb = 32'd5; hiwe = 1'b1; wd = 32'h1234;
      end else begin
        start = 1'b0; hiwe = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; hiwe = 1'b0;
    chk("midrun.hi_hold", 64'(hi), 64'h0000_5555);
    wait_done(bc2, got);
    chk("midrun.done_seen", 64'(got), 64'd1);
    chk("midrun.busy_cycles", 64'(bc + bc2), 64'd33);
    chk("midrun.hi", 64'(hi), 64'd1);
    chk("midrun.lo", 64'(lo), 64'd3);
    @(negedge clk);
    chk("midrun.idle_after", 64'(busy), 64'd0);

    // Reset in the middle of RUN abandons the operation.
    issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid.busy", 64'(busy), 64'd0);
    chk("rst_mid.done", 64'(done), 64'd0);
    chk("rst_mid.hi", 64'(hi), 64'd0);
    chk("rst_mid.lo", 64'(lo), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) seen = 1'b1;
      @(negedge clk);
    end
    chk("rst_mid.no_done", 64'(seen), 64'd0);
    run_check("rst_mid.fresh", 2'b00, 32'd6, 32'd7, {32'd0, 32'd42});

    // Random ops issued back-to-back on each done cycle.
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: ra = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      run_check($sformatf("rnd%0d", i), ro, ra, rb, model(ro, ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
